// File: rtl/volume_controller.sv
// Volume setpoint keeper with remote/host/mute inputs and a rate-limited
// attenuator writer that walks the last written code one step at a time.
module volume_controller #(
   parameter logic [7:0]  VOL_MAX     = 8'd200,
   parameter logic [7:0]  VOL_DEFAULT = 8'd100,
   parameter logic [7:0]  STEP        = 8'd4,
   parameter logic [15:0] RAMP_DIV    = 16'd50000
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       Up,
   input  logic       Down,
   input  logic       Mute,
   input  logic       HostValid,
   input  logic [7:0] HostVolume,
   output logic       HostReady,
   output logic       WrValid,
   output logic [7:0] WrData,
   input  logic       WrReady,
   output logic [7:0] Volume,
   output logic       Muted,
   output logic       Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TICK  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t      state;
   state_t      nextState;
   logic [7:0]  current;
   logic [7:0]  nextCurrent;
   logic [15:0] count;
   logic [15:0] nextCount;
   logic [7:0]  target;

   logic       upPrev;
   logic       downPrev;
   logic       upEdge;
   logic       downEdge;
   logic       hostAccept;
   logic [8:0] upSum;
   logic [8:0] downDiff;
   logic [7:0] hostClamped;

   assign upEdge      = Up & ~upPrev;
   assign downEdge    = Down & ~downPrev;
   assign hostAccept  = HostValid & HostReady;
   assign upSum       = {1'b0, Volume} + {1'b0, STEP};
   assign downDiff    = {1'b0, Volume} - {1'b0, STEP};
   assign hostClamped = (HostVolume > VOL_MAX) ? VOL_MAX : HostVolume;

   // Previous-value registers start high so a remote held down through reset is not an event
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         upPrev    <= 1'b1;
         downPrev  <= 1'b1;
         HostReady <= 1'b0;
      end else begin
         upPrev    <= Up;
         downPrev  <= Down;
         HostReady <= 1'b1;
      end
   end

   // Setpoint update: host beats mute beats remote; a borrow in bit 8 means the step went below zero
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Volume <= VOL_DEFAULT;
         Muted  <= 1'b0;
      end else if (hostAccept) begin
         Volume <= hostClamped;
         Muted  <= 1'b0;
      end else if (Mute) begin
         Muted  <= ~Muted;
      end else if (upEdge && !downEdge) begin
         Volume <= (upSum > {1'b0, VOL_MAX}) ? VOL_MAX : upSum[7:0];
         Muted  <= 1'b0;
      end else if (downEdge && !upEdge) begin
         Volume <= downDiff[8] ? 8'd0 : downDiff[7:0];
         Muted  <= 1'b0;
      end
   end

   assign target = Muted ? 8'd0 : Volume;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         current <= 8'd0;
         count   <= 16'd0;
      end else begin
         state   <= nextState;
         current <= nextCurrent;
         count   <= nextCount;
      end
   end

   // Target is re-sampled when the divider expires, so mid-ramp changes steer the next step
   always_comb begin
      nextState   = state;
      nextCurrent = current;
      nextCount   = count;
      WrValid     = 1'b0;
      case (state)
         IDLE: begin
            if (current != target) begin
               nextCount = RAMP_DIV - 16'd1;
               nextState = TICK;
            end
         end
         TICK: begin
            if (count == 16'd0) begin
               if (current == target) begin
                  nextState = IDLE;
               end else begin
                  nextCurrent = (current < target) ? current + 8'd1 : current - 8'd1;
                  nextState   = WRITE;
               end
            end else begin
               nextCount = count - 16'd1;
            end
         end
         WRITE: begin
            WrValid = 1'b1;
            if (WrReady) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign WrData = current;
   assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_volume_controller.sv
// Directed self-checking bench for volume_controller with a fast ramp divider
// and a small default volume so soft-start and ramps stay short.
module tb_volume_controller;

   logic       Clk;
   logic       nReset;
   logic       Up;
   logic       Down;
   logic       Mute;
   logic       HostValid;
   logic [7:0] HostVolume;
   logic       HostReady;
   logic       WrValid;
   logic [7:0] WrData;
   logic       WrReady;
   logic [7:0] Volume;
   logic       Muted;
   logic       Busy;

   int errors = 0;
   int checks = 0;

   volume_controller #(
      .VOL_MAX     (8'd200),
      .VOL_DEFAULT (8'd8),
      .STEP        (8'd4),
      .RAMP_DIV    (16'd4)
   ) dut (
      .Clk        (Clk),
      .nReset     (nReset),
      .Up         (Up),
      .Down       (Down),
      .Mute       (Mute),
      .HostValid  (HostValid),
      .HostVolume (HostVolume),
      .HostReady  (HostReady),
      .WrValid    (WrValid),
      .WrData     (WrData),
      .WrReady    (WrReady),
      .Volume     (Volume),
      .Muted      (Muted),
      .Busy       (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs from a falling edge; Host and Mute are pulses, Up/Down are levels
   task automatic applyStimulus(input logic host, input logic [7:0] hostVol, input logic mute,
                                input logic up, input logic down);
      HostValid  = host;
      HostVolume = hostVol;
      Mute       = mute;
      Up         = up;
      Down       = down;
      @(negedge Clk);
      HostValid  = 1'b0;
      Mute       = 1'b0;
   endtask

   // Waits for the next write, checking its data and the TICK dwell before it
   task automatic expectWrite(input logic [7:0] expData, input string tag);
      int ticks = 0;
      int guard = 0;
      @(negedge Clk);
      while (!Busy && guard < 100) begin
         @(negedge Clk);
         guard++;
      end
      while (Busy && !WrValid && guard < 100) begin
         ticks++;
         @(negedge Clk);
         guard++;
      end
      checkOutput({tag, "_valid"}, WrValid, 1);
      checkOutput({tag, "_data"}, WrData, expData);
      checkOutput({tag, "_lat"}, ticks, 4);
   endtask

   initial begin
      nReset     = 1'b0;
      Up         = 1'b0;
      Down       = 1'b0;
      Mute       = 1'b0;
      HostValid  = 1'b0;
      HostVolume = 8'd0;
      WrReady    = 1'b1;
      #23;
      checkOutput("rst_volume", Volume, 8);
      checkOutput("rst_muted", Muted, 0);
      checkOutput("rst_wrvalid", WrValid, 0);
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_hostready", HostReady, 0);

      // Soft-start from 0 up to the default
      @(negedge Clk);
      nReset = 1'b1;
      for (int i = 1; i <= 8; i++) expectWrite(i[7:0], $sformatf("soft%0d", i));
      @(negedge Clk);
      checkOutput("soft_busy", Busy, 0);
      checkOutput("soft_volume", Volume, 8);
      checkOutput("hostready", HostReady, 1);

      // Mute ramps down to zero, Up unmutes and ramps to the new setpoint
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("mute_muted", Muted, 1);
      checkOutput("mute_volume", Volume, 8);
      for (int i = 7; i >= 0; i--) expectWrite(i[7:0], $sformatf("mute%0d", i));
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("unmute_muted", Muted, 0);
      checkOutput("unmute_volume", Volume, 12);
      for (int i = 1; i <= 12; i++) expectWrite(i[7:0], $sformatf("unmute%0d", i));
      @(negedge Clk);
      checkOutput("unmute_busy", Busy, 0);

      // Write stalled by WrReady low
      WrReady = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("down_volume", Volume, 8);
      expectWrite(8'd11, "stall11");
      Down = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         checkOutput($sformatf("stall_valid%0d", i), WrValid, 1);
         checkOutput($sformatf("stall_data%0d", i), WrData, 11);
      end
      WrReady = 1'b1;
      expectWrite(8'd10, "stall10");
      expectWrite(8'd9, "stall9");
      expectWrite(8'd8, "stall8");
      @(negedge Clk);
      checkOutput("stall_busy", Busy, 0);

      // Reset in the middle of a stalled write; Up held across release
      WrReady = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("up12_volume", Volume, 12);
      expectWrite(8'd9, "prerst9");
      @(negedge Clk);
      nReset = 1'b0;
      #1;
      checkOutput("midrst_wrvalid", WrValid, 0);
      checkOutput("midrst_volume", Volume, 8);
      checkOutput("midrst_muted", Muted, 0);
      checkOutput("midrst_busy", Busy, 0);
      @(negedge Clk);
      @(negedge Clk);
      nReset  = 1'b1;
      WrReady = 1'b1;
      for (int i = 1; i <= 8; i++) expectWrite(i[7:0], $sformatf("resoft%0d", i));
      @(negedge Clk);
      checkOutput("resoft_volume", Volume, 8);
      checkOutput("resoft_busy", Busy, 0);

      // Setpoint arithmetic, clamping and event priority
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("pri_mute", Muted, 1);
      applyStimulus(1'b1, 8'd198, 1'b0, 1'b0, 1'b0);
      checkOutput("host198_volume", Volume, 198);
      checkOutput("host198_muted", Muted, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("up_clamp", Volume, 200);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("up_at_max", Volume, 200);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("up_held", Volume, 200);
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      checkOutput("host2", Volume, 2);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("down_floor", Volume, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
      checkOutput("updown_both", Volume, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd50, 1'b1, 1'b0, 1'b0);
      checkOutput("host_mute_vol", Volume, 50);
      checkOutput("host_mute_muted", Muted, 0);
      applyStimulus(1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
      checkOutput("host_up_vol", Volume, 100);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd250, 1'b0, 1'b1, 1'b0);
      checkOutput("host250_up", Volume, 200);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("mute_down_muted", Muted, 1);
      checkOutput("mute_down_vol", Volume, 200);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("up_unmute_muted", Muted, 0);
      checkOutput("up_unmute_vol", Volume, 200);
      checkOutput("hostready_end", HostReady, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
